// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
// Shared types and constants for the multibyte carry-skip adder sequencer.
//   CSA_BYTE_W  : width of one operand byte handled per cycle
//   CSA_BLK_W   : width of one carry-skip block inside the byte slice
//   seq_state_t : sequencer state (IDLE = waiting for byte 0, ACCUM = mid-op)
//   csa_byte_t  : one operand / sum byte
// ---------------------------------------------------------------------------
package csa_pkg;

    localparam int CSA_BYTE_W = 8;
    localparam int CSA_BLK_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } seq_state_t;

    typedef logic [CSA_BYTE_W-1:0] csa_byte_t;

endpackage

// File: rtl/csa8_slice.sv
// ---------------------------------------------------------------------------
// csa8_slice
// Combinational 8-bit carry-skip adder built from two 4-bit ripple blocks.
// Each block computes its ripple carry and a block propagate; when every bit
// of the block propagates, the block carry-in is passed straight through.
// Ports:
//   a, b  : 8-bit addends
//   cin   : carry into bit 0
//   sum   : 8-bit sum
//   cout  : carry out of bit 7
// ---------------------------------------------------------------------------
module csa8_slice
    import csa_pkg::*;
(
    input  csa_byte_t a,
    input  csa_byte_t b,
    input  logic      cin,
    output csa_byte_t sum,
    output logic      cout
);

    localparam int NBLK = CSA_BYTE_W / CSA_BLK_W;

    logic blk_c;
    logic blk_cin;
    logic rip_c;
    logic blk_p;
    logic bit_p;

    always_comb begin
        sum     = '0;
        blk_c   = cin;
        blk_cin = 1'b0;
        rip_c   = 1'b0;
        blk_p   = 1'b0;
        bit_p   = 1'b0;
        for (int blk = 0; blk < NBLK; blk++) begin
            blk_cin = blk_c;
            rip_c   = blk_c;
            blk_p   = 1'b1;
            for (int i = 0; i < CSA_BLK_W; i++) begin
                bit_p = a[blk*CSA_BLK_W + i] ^ b[blk*CSA_BLK_W + i];
                sum[blk*CSA_BLK_W + i] = bit_p ^ rip_c;
                rip_c = (a[blk*CSA_BLK_W + i] & b[blk*CSA_BLK_W + i]) | (bit_p & rip_c);
                blk_p = blk_p & bit_p;
            end
            // Skip mux: a fully propagating block forwards its carry-in.
            blk_c = blk_p ? blk_cin : rip_c;
        end
        cout = blk_c;
    end

endmodule

// File: rtl/csa_multibyte_sequencer.sv
// ---------------------------------------------------------------------------
// csa_multibyte_sequencer
// Adds two NBYTES-wide operands presented as a stream of byte pairs, least
// significant byte first. One csa8_slice handles a byte per cycle; the carry
// between bytes is held in a register. Sum bytes leave through a single-entry
// registered output with valid/ready; the final carry-out and signed overflow
// are reported with the last byte.
//
// Optional feature: define CSA_SEQ_SUB_EN to add the in_sub port. in_sub is
// captured with byte 0 and selects A-B (two's complement) for the whole op.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input byte-pair handshake
//   in_a, in_b            : operand bytes, LSB first
//   in_sub                : subtract select (only with CSA_SEQ_SUB_EN)
//   out_valid/out_ready   : output byte handshake
//   out_sum               : sum byte
//   out_last              : marks byte NBYTES-1
//   out_cout, out_ovf     : final carry-out / signed overflow (0 unless last)
//   busy                  : an operation is partially accepted
// ---------------------------------------------------------------------------
module csa_multibyte_sequencer
    import csa_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      in_valid,
    output logic      in_ready,
    input  csa_byte_t in_a,
    input  csa_byte_t in_b,
`ifdef CSA_SEQ_SUB_EN
    input  logic      in_sub,
`endif
    output logic      out_valid,
    input  logic      out_ready,
    output csa_byte_t out_sum,
    output logic      out_last,
    output logic      out_cout,
    output logic      out_ovf,
    output logic      busy
);

    localparam int                IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             out_valid_q, out_valid_d;
    csa_byte_t        out_sum_q, out_sum_d;
    logic             out_last_q, out_last_d;
    logic             out_cout_q, out_cout_d;
    logic             out_ovf_q, out_ovf_d;
`ifdef CSA_SEQ_SUB_EN
    logic             sub_q, sub_d;
`endif

    logic      in_fire;
    logic      out_fire;
    logic      first_byte;
    logic      last_byte;
    logic      sub_eff;
    csa_byte_t b_eff;
    logic      slice_cin;
    csa_byte_t slice_sum;
    logic      slice_cout;

    // Output register accepts a new byte whenever it is empty or draining.
    assign in_ready = !out_valid_q | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;

    assign first_byte = (idx_q == '0);
    assign last_byte  = (idx_q == LAST_IDX);

`ifdef CSA_SEQ_SUB_EN
    // Byte 0 uses the live in_sub; later bytes use the value latched with it.
    assign sub_eff = first_byte ? in_sub : sub_q;
`else
    assign sub_eff = 1'b0;
`endif

    assign b_eff     = in_b ^ {CSA_BYTE_W{sub_eff}};
    assign slice_cin = first_byte ? sub_eff : carry_q;

    csa8_slice u_slice (
        .a    (in_a),
        .b    (b_eff),
        .cin  (slice_cin),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
`ifdef CSA_SEQ_SUB_EN
        sub_d       = sub_q;
        if (in_fire && first_byte) begin
            sub_d = in_sub;
        end
`endif
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_sum_d   = slice_sum;
            out_last_d  = last_byte;
            if (last_byte) begin
                out_cout_d = slice_cout;
                out_ovf_d  = (in_a[CSA_BYTE_W-1] == b_eff[CSA_BYTE_W-1]) &
                             (slice_sum[CSA_BYTE_W-1] != in_a[CSA_BYTE_W-1]);
                idx_d      = '0;
                carry_d    = 1'b0;
                state_d    = IDLE;
            end else begin
                out_cout_d = 1'b0;
                out_ovf_d  = 1'b0;
                idx_d      = idx_q + IDX_W'(1);
                carry_d    = slice_cout;
                state_d    = ACCUM;
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
`ifdef CSA_SEQ_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
`ifdef CSA_SEQ_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_csa_multibyte_sequencer.sv
// ---------------------------------------------------------------------------
// tb_csa_multibyte_sequencer
// Bench for csa_multibyte_sequencer with NBYTES=4. A table of operand pairs
// with expected 32-bit results is streamed byte by byte; each accepted byte
// pushes its expected output onto a queue that a negedge monitor pops when
// the DUT hands the byte downstream. Hand-written sequences cover
// backpressure, back-to-back operations and reset in mid-operation.
// ---------------------------------------------------------------------------
module tb_csa_multibyte_sequencer;

    localparam int NB = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] exp_s;
        logic        exp_c;
        logic        exp_o;
    } vec_t;

    typedef struct {
        logic [7:0] sum;
        logic       last;
        logic       cout;
        logic       ovf;
    } item_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_last;
    logic       out_cout;
    logic       out_ovf;
    logic       busy;

    int    n_checks;
    int    n_pass;
    item_t exp_q[$];
    vec_t  vecs[$];
    time   last_fire_t;
    time   first_fire_t;
    time   t_start;

    csa_multibyte_sequencer #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef CSA_SEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every byte handed downstream must match the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", {out_valid, out_sum}, 9'h0);
            end else begin
                item_t e;
                e = exp_q.pop_front();
                check("sb_byte", {out_sum, out_last, out_cout, out_ovf},
                      {e.sum, e.last, e.cout, e.ovf});
            end
        end
    end

    task automatic send_byte(input logic [7:0] a, input logic [7:0] b, input logic sub,
                             input logic last, input logic [7:0] exp_s,
                             input logic exp_c, input logic exp_o, input int stall);
        int guard;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        exp_q.push_back('{sum: exp_s, last: last, cout: exp_c, ovf: exp_o});
        last_fire_t = $time;
        #1;
        in_valid = 1'b0;
        if (stall > 0) out_ready = 1'b0;
        @(negedge clk);
        check("latency", {out_valid, out_sum}, {1'b1, exp_s});
        for (int i = 0; i < stall; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_hold", {out_valid, out_sum, out_last}, {1'b1, exp_s, last});
        end
        if (stall > 0) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
    endtask

    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic [31:0] exp_s, input logic exp_c, input logic exp_o,
                           input int stall_byte, input int stall_n);
        for (int k = 0; k < NB; k++) begin
            // in_sub is toggled after byte 0 to show it is ignored there.
            send_byte(a[8*k +: 8], b[8*k +: 8], (k == 0) ? sub : ~sub, (k == NB-1),
                      exp_s[8*k +: 8], (k == NB-1) ? exp_c : 1'b0,
                      (k == NB-1) ? exp_o : 1'b0, (k == stall_byte) ? stall_n : 0);
            if (k == 0) first_fire_t = last_fire_t;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_sub    = 1'b0;
        out_ready = 1'b1;

        vecs.push_back('{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1});
        vecs.push_back('{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0});
        vecs.push_back('{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0});
`ifdef CSA_SEQ_SUB_EN
        vecs.push_back('{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0});
        vecs.push_back('{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0});
        vecs.push_back('{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1});
`endif

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_outputs", {out_valid, out_sum, out_last, out_cout, out_ovf},
              {1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Table-driven operations, streamed back to back.
        foreach (vecs[i]) begin
            send_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp_s,
                    vecs[i].exp_c, vecs[i].exp_o, -1, 0);
        end

        // Back-to-back: carry of the first op must not reach the second.
        send_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, -1, 0);
        t_start = first_fire_t;
        send_op(32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, -1, 0);
        check("b2b_span", 64'(last_fire_t - t_start), 64'd70);

        // Backpressure for 3 cycles after byte 1.
        send_op(32'h0001FFFF, 32'h00000001, 1'b0, 32'h00020000, 1'b0, 1'b0, 1, 3);

        // Reset in the middle of an operation.
        send_byte(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        send_byte(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        check("midop_busy", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_state", {out_valid, busy}, 2'b00);
        send_op(32'h00000002, 32'h00000003, 1'b0, 32'h00000005, 1'b0, 1'b0, -1, 0);

        // Random additions against a full-width model.
        for (int r = 0; r < 4; r++) begin
            logic [31:0] ra, rb;
            logic [32:0] full;
            ra   = $urandom;
            rb   = $urandom;
            full = {1'b0, ra} + {1'b0, rb};
            send_op(ra, rb, 1'b0, full[31:0], full[32],
                    (ra[31] == rb[31]) && (full[31] != ra[31]), r, r & 1);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
